// File: rtl/shifter_palette.sv
// shifter_palette
//   Colour-lookup stage behind the shifter shift array. Maps the 4-bit pixel
//   index through a 16-entry CPU-loadable palette to 4-bit-per-channel RGB
//   and a monochrome pixel, with resolution-dependent index masking and
//   blanking. Two pixClkEn-gated pipeline stages feed the DAC/scan-doubler.
//
// Ports
//   clk32        in   system clock, all logic on posedge
//   nReset       in   asynchronous active-low reset
//   pixClkEn     in   pixel clock enable (advances both pipeline stages)
//   rez[1:0]     in   0 low, 1 mid, 2/3 high resolution
//   ste          in   1 = STe 4-bit palette, 0 = ST 3-bit palette
//   blank        in   forces black output (pipelined with the index)
//   color_index  in   pixel index from the shift array
//   bus_cs       in   palette register select, held for the whole access
//   bus_rw       in   1 read, 0 write
//   bus_a[3:0]   in   palette entry number (address bits A4..A1)
//   bus_nuds     in   active-low upper byte strobe (bits 11:8)
//   bus_nlds     in   active-low lower byte strobe (bits 7:0)
//   bus_din      in   write data
//   bus_dout     out  read data {4'b0, entry}
//   bus_dtack    out  access acknowledge
//   r, g, b      out  4-bit colour channels
//   mono         out  high-res pixel, 1 = white
module shifter_palette (
  input  logic        clk32,
  input  logic        nReset,
  input  logic        pixClkEn,
  input  logic [1:0]  rez,
  input  logic        ste,
  input  logic        blank,
  input  logic [3:0]  color_index,
  input  logic        bus_cs,
  input  logic        bus_rw,
  input  logic [3:0]  bus_a,
  input  logic        bus_nuds,
  input  logic        bus_nlds,
  input  logic [15:0] bus_din,
  output logic [15:0] bus_dout,
  output logic        bus_dtack,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        mono
);

  // Nibble as stored -> 4-bit DAC level. STe keeps its LSB in bit 3;
  // ST replicates bit 2 into the LSB so full scale still reaches $F.
  function automatic logic [3:0] nib(input logic [3:0] x, input logic ste_m);
    return ste_m ? {x[2:0], x[3]} : {x[2:0], x[2]};
  endfunction

  logic [11:0] pal_q [16];

  logic        bus_cs_q;
  logic [15:0] bus_dout_q;
  logic        bus_dtack_q, bus_dtack_d;

  logic [3:0]  idx_q;
  logic        blank_q;
  logic [1:0]  rez_q;

  logic [3:0]  r_q, g_q, b_q, r_d, g_d, b_d;
  logic        mono_q, mono_d;

  logic        start;
  logic        wr_en;
  logic [11:0] wr_data;
  logic [3:0]  entry_sel;
  logic [11:0] entry;
  logic        mono_pix;

  // Upper data bits have no storage behind them.
  logic unused_din;
  assign unused_din = ^bus_din[15:12];

  // An access starts on the first edge that sees bus_cs high; the stored
  // copy of bus_cs guarantees a single write per select assertion.
  assign start       = bus_cs & ~bus_cs_q;
  assign wr_en       = start & ~bus_rw;
  assign wr_data     = ste ? bus_din[11:0] : (bus_din[11:0] & 12'h777);
  assign bus_dtack_d = bus_cs & bus_cs_q;

  always_ff @(posedge clk32 or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < 16; i++) pal_q[i] <= '0;
    end else if (wr_en) begin
      if (!bus_nuds) pal_q[bus_a][11:8] <= wr_data[11:8];
      if (!bus_nlds) pal_q[bus_a][7:0]  <= wr_data[7:0];
    end
  end

  always_ff @(posedge clk32 or negedge nReset) begin
    if (!nReset) begin
      bus_cs_q    <= 1'b0;
      bus_dout_q  <= '0;
      bus_dtack_q <= 1'b0;
    end else begin
      bus_cs_q    <= bus_cs;
      bus_dtack_q <= bus_dtack_d;
      if (start) bus_dout_q <= {4'h0, pal_q[bus_a]};
    end
  end

  // Stage-2 decode works only from stage-1 registers, so a rez change can
  // never mix modes within one pixel. It reads pal_q before any write on the
  // same edge lands, giving the pre-write colour on a collision.
  always_comb begin
    entry_sel = 4'h0;
    case (rez_q)
      2'd0:    entry_sel = idx_q;
      2'd1:    entry_sel = {2'b00, idx_q[1:0]};
      default: entry_sel = 4'h0;
    endcase
    entry    = pal_q[entry_sel];
    mono_pix = idx_q[0] ^ pal_q[0][0];

    r_d    = 4'h0;
    g_d    = 4'h0;
    b_d    = 4'h0;
    mono_d = 1'b0;
    if (!blank_q) begin
      if (rez_q[1]) begin
        mono_d = mono_pix;
        r_d    = {4{mono_pix}};
        g_d    = {4{mono_pix}};
        b_d    = {4{mono_pix}};
      end else begin
        r_d = nib(entry[11:8], ste);
        g_d = nib(entry[7:4], ste);
        b_d = nib(entry[3:0], ste);
      end
    end
  end

  always_ff @(posedge clk32 or negedge nReset) begin
    if (!nReset) begin
      idx_q   <= '0;
      blank_q <= 1'b0;
      rez_q   <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      mono_q  <= 1'b0;
    end else if (pixClkEn) begin
      idx_q   <= color_index;
      blank_q <= blank;
      rez_q   <= rez;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      mono_q  <= mono_d;
    end
  end

  assign bus_dout  = bus_dout_q;
  assign bus_dtack = bus_dtack_q;
  assign r         = r_q;
  assign g         = g_q;
  assign b         = b_q;
  assign mono      = mono_q;

endmodule

// File: tb/tb_shifter_palette.sv
// tb_shifter_palette
//   Directed scenarios followed by randomized traffic, all compared against
//   a behavioural palette model (array of entries plus a queue of pixels in
//   flight) that computes colours straight from the lookup rules.
module tb_shifter_palette;

  logic        clk32;
  logic        nReset;
  logic        pixClkEn;
  logic [1:0]  rez;
  logic        ste;
  logic        blank;
  logic [3:0]  color_index;
  logic        bus_cs;
  logic        bus_rw;
  logic [3:0]  bus_a;
  logic        bus_nuds;
  logic        bus_nlds;
  logic [15:0] bus_din;
  logic [15:0] bus_dout;
  logic        bus_dtack;
  logic [3:0]  r, g, b;
  logic        mono;

  shifter_palette dut (
    .clk32       (clk32),
    .nReset      (nReset),
    .pixClkEn    (pixClkEn),
    .rez         (rez),
    .ste         (ste),
    .blank       (blank),
    .color_index (color_index),
    .bus_cs      (bus_cs),
    .bus_rw      (bus_rw),
    .bus_a       (bus_a),
    .bus_nuds    (bus_nuds),
    .bus_nlds    (bus_nlds),
    .bus_din     (bus_din),
    .bus_dout    (bus_dout),
    .bus_dtack   (bus_dtack),
    .r           (r),
    .g           (g),
    .b           (b),
    .mono        (mono)
  );

  initial clk32 = 1'b0;
  always #5 clk32 = ~clk32;

  logic [15:0] pix_obs;
  assign pix_obs = {3'b000, r, g, b, mono};

  // ---------------- reference model ----------------
  typedef struct {
    int idx;
    bit blk;
    int rz;
  } pix_t;

  logic [11:0] pal_m [16];
  pix_t        pipe_m [$];
  bit          cs_prev;
  logic [15:0] exp_pix;
  logic [15:0] exp_dout;
  bit          exp_dtack;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Colour of one pixel, packed as {3'b0, r, g, b, mono}.
  function automatic logic [15:0] colour(pix_t p);
    int e, x, n, acc;
    if (p.blk) return 16'h0000;
    if (p.rz >= 2)
      return (((p.idx % 2) ^ int'(pal_m[0] % 2)) != 0) ? 16'h1FFF : 16'h0000;
    e   = (p.rz == 0) ? p.idx : (p.idx % 4);
    acc = 0;
    for (int c = 0; c < 3; c++) begin
      x = (int'(pal_m[e]) >> (8 - 4 * c)) % 16;
      if (ste) n = (x * 2) % 16 + x / 8;
      else     n = (x % 8) * 2 + (x / 4) % 2;
      acc = acc * 16 + n;
    end
    return 16'(acc * 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) pal_m[i] = 12'h000;
    pipe_m.delete();
    pipe_m.push_back('{0, 1'b0, 0});
    cs_prev   = 1'b0;
    exp_pix   = 16'h0000;
    exp_dout  = 16'h0000;
    exp_dtack = 1'b0;
  endtask

  // One clk32 cycle: update the model with the pre-edge inputs, then check.
  task automatic step(input bit en);
    pix_t p;
    bit   start;
    pixClkEn = en;
    start = bus_cs && !cs_prev;
    if (en) begin
      pipe_m.push_back('{int'(color_index), bit'(blank), int'(rez)});
      p = pipe_m.pop_front();
      exp_pix = colour(p);
    end
    if (start) begin
      exp_dout = {4'h0, pal_m[bus_a]};
      if (!bus_rw) begin
        if (!bus_nuds) pal_m[bus_a][11:8] = bus_din[11:8] & (ste ? 4'hF : 4'h7);
        if (!bus_nlds) pal_m[bus_a][7:0]  = bus_din[7:0]  & (ste ? 8'hFF : 8'h77);
      end
    end
    exp_dtack = bus_cs && cs_prev;
    cs_prev   = bus_cs;
    @(posedge clk32);
    #1;
    check("pix", pix_obs, exp_pix);
    check("dtack", {15'h0, bus_dtack}, {15'h0, exp_dtack});
    check("dout", bus_dout, exp_dout);
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    model_reset();
    #2;
    check("rst_pix", pix_obs, 16'h0000);
    check("rst_dtack", {15'h0, bus_dtack}, 16'h0000);
    check("rst_dout", bus_dout, 16'h0000);
    @(posedge clk32);
    #1;
    nReset = 1'b1;
  endtask

  task automatic bus_access(input bit rw, input logic [3:0] a, input logic [15:0] d,
                            input bit nu, input bit nl, input bit en0);
    bus_cs   = 1'b1;
    bus_rw   = rw;
    bus_a    = a;
    bus_din  = d;
    bus_nuds = nu;
    bus_nlds = nl;
    step(en0);
    check("dtack_start", {15'h0, bus_dtack}, 16'h0000);
    step(1'b0);
    check("dtack_ack", {15'h0, bus_dtack}, 16'h0001);
    bus_cs   = 1'b0;
    bus_nuds = 1'b1;
    bus_nlds = 1'b1;
    step(1'b0);
    check("dtack_end", {15'h0, bus_dtack}, 16'h0000);
    $display("[TB] %s entry %0d din=%h uds=%0b lds=%0b dout=%h", rw ? "RD" : "WR",
             a, d, !nu, !nl, bus_dout);
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  initial begin
    nReset = 1'b0; pixClkEn = 1'b0; rez = 2'd0; ste = 1'b1; blank = 1'b0;
    color_index = 4'd5; bus_cs = 1'b0; bus_rw = 1'b1; bus_a = 4'd0;
    bus_nuds = 1'b1; bus_nlds = 1'b1; bus_din = 16'h0000;
    #3;
    do_reset();

    // Reset -> outputs
    strobes(4);
    check("reset_rgb", pix_obs, 16'h0000);
    check("reset_dtack", {15'h0, bus_dtack}, 16'h0000);

    // STe write / readback / lookup
    bus_access(1'b0, 4'd5, 16'h0F81, 1'b0, 1'b0, 1'b0);
    bus_access(1'b1, 4'd5, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("ste_readback", bus_dout, 16'h0F81);
    strobes(2);
    check("ste_rgb", pix_obs, {3'b000, 12'hF12, 1'b0});

    // ST masking
    ste = 1'b0;
    bus_access(1'b0, 4'd1, 16'h0FFF, 1'b0, 1'b0, 1'b0);
    bus_access(1'b1, 4'd1, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("st_readback", bus_dout, 16'h0777);
    color_index = 4'd1;
    strobes(2);
    check("st_full", pix_obs, {3'b000, 12'hFFF, 1'b0});
    bus_access(1'b0, 4'd1, 16'h0222, 1'b0, 1'b0, 1'b0);
    strobes(2);
    check("st_222", pix_obs, {3'b000, 12'h444, 1'b0});
    ste = 1'b1;

    // Byte strobes
    bus_access(1'b0, 4'd2, 16'h0123, 1'b0, 1'b0, 1'b0);
    bus_access(1'b0, 4'd2, 16'h0ABC, 1'b0, 1'b1, 1'b0);
    bus_access(1'b1, 4'd2, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("uds_only", bus_dout, 16'h0A23);
    bus_access(1'b0, 4'd2, 16'h0555, 1'b1, 1'b0, 1'b0);
    bus_access(1'b1, 4'd2, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("lds_only", bus_dout, 16'h0A55);

    // Mid rez: index $E folds onto entry 2
    rez = 2'd1; color_index = 4'hE;
    strobes(2);
    check("mid_rez", pix_obs, {3'b000, 12'h5AA, 1'b0});

    // High rez mono polarity
    bus_access(1'b0, 4'd0, 16'h0777, 1'b0, 1'b0, 1'b0);
    rez = 2'd2; color_index = 4'h0;
    strobes(2);
    check("hi_idx0", pix_obs, 16'h1FFF);
    color_index = 4'h1;
    strobes(2);
    check("hi_idx1", pix_obs, 16'h0000);
    bus_access(1'b0, 4'd0, 16'h0776, 1'b0, 1'b0, 1'b0);
    rez = 2'd3;
    strobes(2);
    check("hi_inv_idx1", pix_obs, 16'h1FFF);
    color_index = 4'h0;
    strobes(2);
    check("hi_inv_idx0", pix_obs, 16'h0000);

    // Blank: black exactly two strobes later
    rez = 2'd0; color_index = 4'd2;
    strobes(2);
    blank = 1'b1;
    step(1'b1);
    check("blank_s1", pix_obs, {3'b000, 12'h5AA, 1'b0});
    step(1'b1);
    check("blank_s2", pix_obs, 16'h0000);
    blank = 1'b0;

    // Write/lookup collision on entry 3
    bus_access(1'b0, 4'd3, 16'h0F00, 1'b0, 1'b0, 1'b0);
    color_index = 4'd3;
    strobes(2);
    check("coll_before", pix_obs, {3'b000, 12'hF00, 1'b0});
    bus_access(1'b0, 4'd3, 16'h00F0, 1'b0, 1'b0, 1'b1);
    check("coll_old", pix_obs, {3'b000, 12'hF00, 1'b0});
    step(1'b1);
    check("coll_new", pix_obs, {3'b000, 12'h0F0, 1'b0});

    // Reset in the middle of an access; held select restarts the write
    bus_cs = 1'b1; bus_rw = 1'b0; bus_a = 4'd7; bus_din = 16'h0123;
    bus_nuds = 1'b0; bus_nlds = 1'b0;
    step(1'b0);
    do_reset();
    step(1'b0);
    check("rstmid_start", {15'h0, bus_dtack}, 16'h0000);
    step(1'b0);
    check("rstmid_ack", {15'h0, bus_dtack}, 16'h0001);
    bus_cs = 1'b0; bus_nuds = 1'b1; bus_nlds = 1'b1;
    step(1'b0);
    bus_access(1'b1, 4'd7, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("rstmid_rd", bus_dout, 16'h0123);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      color_index = 4'($urandom);
      blank = ($urandom_range(3) == 0);
      if ($urandom_range(15) == 0) rez = 2'($urandom);
      if ($urandom_range(31) == 0) ste = 1'($urandom);
      if ($urandom_range(5) == 0)
        bus_access(1'($urandom), 4'($urandom), 16'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom));
      else
        step(1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
